// File: rtl/vga_paint_canvas_pkg.sv
// Shared definitions for the VGA paint canvas: default timing, canvas
// geometry, painter state encoding and the fixed 8-entry colour palette.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 29;
  localparam int DEF_CANVAS_W  = 480;
  localparam int DEF_CANVAS_H  = 480;
  localparam int DEF_CANVAS_X0 = 80;
  localparam int DEF_CANVAS_Y0 = 0;
  localparam int DEF_IDX_W     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAINT = 2'd1,
    CLEAR = 2'd2
  } paint_state_e;

  // 12-bit RGB (4 bits per channel) for each colour index
  function automatic logic [11:0] palette_rgb(input logic [2:0] idx);
    logic [11:0] rgb;
    case (idx)
      3'd0:    rgb = 12'hFFF;  // white
      3'd1:    rgb = 12'hF00;  // red
      3'd2:    rgb = 12'hF80;  // orange
      3'd3:    rgb = 12'hFF0;  // yellow
      3'd4:    rgb = 12'h0F0;  // green
      3'd5:    rgb = 12'h00F;  // blue
      3'd6:    rgb = 12'hC0C;  // purple
      default: rgb = 12'h000;  // black
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/vga_paint_canvas_ram.sv
// Simple dual-port framebuffer: one write port for the painter, one
// registered read port for the scan. Read-before-write on an address
// collision, so the scan sees a write one cycle after it happens.
module canvas_ram #(
  parameter int DEPTH  = 230400,
  parameter int ADDR_W = 18,
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write from the painter and registered read for the scan, same edge
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vga_paint_canvas.sv
// VGA timing generator with an indexed-colour paint canvas. The scan runs
// a two-stage pipeline (RAM read, palette lookup) with sync delayed to
// match; a painter FSM stamps square brushes during vblank or clears the
// whole canvas to index 0.
module vga_paint_canvas
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int CANVAS_W  = DEF_CANVAS_W,
  parameter int CANVAS_H  = DEF_CANVAS_H,
  parameter int CANVAS_X0 = DEF_CANVAS_X0,
  parameter int CANVAS_Y0 = DEF_CANVAS_Y0,
  parameter int IDX_W     = DEF_IDX_W
) (
  input  logic             dclk,
  input  logic             clr_n,
  input  logic             paint_en,
  input  logic [9:0]       x_pos,
  input  logic [9:0]       y_pos,
  input  logic [IDX_W-1:0] color_sel,
  input  logic [3:0]       brush_r,
  input  logic             clear_req,
  output logic             clear_busy,
  output logic             vblank_start,
  output logic             hsync,
  output logic             vsync,
  output logic [3:0]       red,
  output logic [3:0]       green,
  output logic [3:0]       blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam int NPIX    = CANVAS_W * CANVAS_H;
  localparam int ADDR_W  = $clog2(NPIX);

  localparam logic [HC_W-1:0] HC_LAST = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] HC_ACT  = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] HS_BEG  = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] HS_END  = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HC_W-1:0] HC_X0   = HC_W'(CANVAS_X0);
  localparam logic [HC_W:0]   HC_CW   = (HC_W + 1)'(CANVAS_W);
  localparam logic [VC_W-1:0] VC_LAST = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] VC_ACT  = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] VS_BEG  = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] VS_END  = VC_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VC_W-1:0] VC_Y0   = VC_W'(CANVAS_Y0);
  localparam logic [VC_W:0]   VC_CH   = (VC_W + 1)'(CANVAS_H);

  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(CANVAS_W);
  localparam logic [ADDR_W-1:0] CLR_LAST   = ADDR_W'(NPIX - 1);
  localparam logic signed [11:0] CW_S      = 12'(CANVAS_W);
  localparam logic signed [11:0] CH_S      = 12'(CANVAS_H);

  // Scan side
  logic [HC_W-1:0]   hc;
  logic [VC_W-1:0]   vc;
  logic [HC_W:0]     hc_off;
  logic [VC_W:0]     vc_off;
  logic              act_p0, hit_p0, hs_p0, vs_p0;
  logic              vld_p1, hs_p1, vs_p1;
  logic [ADDR_W-1:0] rd_addr;
  logic [IDX_W-1:0]  rd_data;

  // Painter side
  paint_state_e      state, nxt_state;
  logic [9:0]        bx, by;
  logic [IDX_W-1:0]  bcol;
  logic [3:0]        br;
  logic [4:0]        pi, pj, span;
  logic              paint_last, clr_last;
  logic [ADDR_W-1:0] clr_cnt;
  logic signed [11:0] px, py;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [IDX_W-1:0]  wr_data;

  // ---- stage 0: raster counters ----
  // Horizontal counter wraps each line; vertical advances on that wrap
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == HC_LAST) begin
      hc <= '0;
      vc <= (vc == VC_LAST) ? '0 : vc + 1'b1;
    end else begin
      hc <= hc + 1'b1;
    end
  end

  // Decode region flags, sync levels and the canvas read address
  always_comb begin
    // Offsets go "negative" (very large) left of / above the canvas
    hc_off  = {1'b0, hc} - {1'b0, HC_X0};
    vc_off  = {1'b0, vc} - {1'b0, VC_Y0};
    act_p0  = (hc < HC_ACT) && (vc < VC_ACT);
    hit_p0  = act_p0 && (hc_off < HC_CW) && (vc_off < VC_CH);
    hs_p0   = !((hc >= HS_BEG) && (hc < HS_END));
    vs_p0   = !((vc >= VS_BEG) && (vc < VS_END));
    rd_addr = ADDR_W'(vc_off) * ROW_STRIDE + ADDR_W'(hc_off);
  end

  assign vblank_start = (hc == '0) && (vc == VC_ACT);

  // ---- stage 1: RAM read, flags follow ----
  // Carry the canvas-hit and sync levels alongside the RAM read
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      vld_p1 <= 1'b0;
      hs_p1  <= 1'b1;
      vs_p1  <= 1'b1;
    end else begin
      vld_p1 <= hit_p0;
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
    end
  end

  canvas_ram #(
    .DEPTH  (NPIX),
    .ADDR_W (ADDR_W),
    .DATA_W (IDX_W)
  ) u_ram (
    .clk     (dclk),
    .we      (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // ---- stage 2: palette lookup, registered outputs ----
  // Off-canvas and blanking pixels are both driven black
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      {red, green, blue} <= '0;
    end else begin
      hsync <= hs_p1;
      vsync <= vs_p1;
      {red, green, blue} <= vld_p1 ? palette_rgb(3'(rd_data)) : 12'h000;
    end
  end

  // Painter state register
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= nxt_state;
  end

  assign span       = {br, 1'b0};
  assign paint_last = (pi == span) && (pj == span);
  assign clr_last   = (clr_cnt == CLR_LAST);

  // Painter next state: clear wins over paint, a running clear is never interrupted
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE: begin
        if (clear_req)                     nxt_state = CLEAR;
        else if (vblank_start && paint_en) nxt_state = PAINT;
      end
      PAINT: begin
        if (clear_req)       nxt_state = CLEAR;
        else if (paint_last) nxt_state = IDLE;
      end
      CLEAR: begin
        if (clr_last) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Walk counters: clear address and brush row/column, zeroed outside their state
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      clr_cnt <= '0;
      pi      <= '0;
      pj      <= '0;
    end else begin
      clr_cnt <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
      if (state != PAINT) begin
        pi <= '0;
        pj <= '0;
      end else if (pj == span) begin
        pj <= '0;
        pi <= pi + 1'b1;
      end else begin
        pj <= pj + 1'b1;
      end
    end
  end

  // Capture the brush parameters on the vblank that starts a paint
  always_ff @(posedge dclk) begin
    if ((state == IDLE) && (nxt_state == PAINT)) begin
      bx   <= x_pos;
      by   <= y_pos;
      bcol <= color_sel;
      br   <= brush_r;
    end
  end

  // Painter outputs: busy flag and RAM write port; clipped points write nothing
  always_comb begin
    clear_busy = (state == CLEAR);
    px = $signed({2'b00, bx}) - $signed({8'b0, br}) + $signed({7'b0, pj});
    py = $signed({2'b00, by}) - $signed({8'b0, br}) + $signed({7'b0, pi});
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt;
      end
      PAINT: begin
        wr_en   = (px >= 12'sd0) && (px < CW_S) && (py >= 12'sd0) && (py < CH_S);
        wr_addr = ADDR_W'(py) * ROW_STRIDE + ADDR_W'(px);
        wr_data = bcol;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vga_paint_canvas.sv
// Bench for vga_paint_canvas on a reduced raster (46x31 total, 16x16 canvas
// at (8,4)). A per-cycle reference of the raster, painter and canvas pushes
// the expected pixel/sync word into a queue that is popped two cycles later
// against the DUT outputs.
module tb_vga_paint_canvas;
  import vga_pkg::*;

  localparam int HA = 32, HFP = 4, HS = 6, HBP = 4;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VA = 24, VFP = 2, VS = 2, VBP = 3;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int CW = 16, CH = 16, CX0 = 8, CY0 = 4;
  localparam int NPIX = CW * CH;
  localparam logic [11:0] PAL [8] = '{12'hFFF, 12'hF00, 12'hF80, 12'hFF0,
                                      12'h0F0, 12'h00F, 12'hC0C, 12'h000};

  logic       dclk = 1'b0;
  logic       clr_n = 1'b0;
  logic       paint_en = 1'b0;
  logic [9:0] x_pos = '0;
  logic [9:0] y_pos = '0;
  logic [2:0] color_sel = '0;
  logic [3:0] brush_r = '0;
  logic       clear_req = 1'b0;
  logic       clear_busy, vblank_start, hsync, vsync;
  logic [3:0] red, green, blue;

  vga_paint_canvas #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .CANVAS_W (CW), .CANVAS_H (CH), .CANVAS_X0 (CX0), .CANVAS_Y0 (CY0),
    .IDX_W    (3)
  ) dut (
    .dclk         (dclk),
    .clr_n        (clr_n),
    .paint_en     (paint_en),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .color_sel    (color_sel),
    .brush_r      (brush_r),
    .clear_req    (clear_req),
    .clear_busy   (clear_busy),
    .vblank_start (vblank_start),
    .hsync        (hsync),
    .vsync        (vsync),
    .red          (red),
    .green        (green),
    .blue         (blue)
  );

  always #5 dclk = ~dclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic [13:0] val;
    logic [13:0] mask;
  } sb_t;

  sb_t        sb_q[$];
  bit         sb_on = 1'b0;
  int         mhc = 0, mvc = 0;
  logic [2:0] canvas [NPIX];
  bit         canvas_ok = 1'b0;
  int         m_mode = 0;   // 0 idle, 1 paint, 2 clear
  int         m_left = 0;
  int         busy_run = 0;

  task automatic stamp(input int x, input int y, input int r, input int c);
    for (int dy = -r; dy <= r; dy++)
      for (int dx = -r; dx <= r; dx++)
        if (x + dx >= 0 && x + dx < CW && y + dy >= 0 && y + dy < CH)
          canvas[(y + dy) * CW + x + dx] = 3'(c);
  endtask

  // Reference model and scoreboard, evaluated mid-cycle
  always @(negedge dclk) begin : sb
    sb_t        e;
    logic [13:0] obs;
    bit         act, hit;
    int         cx, cy, r;
    if (sb_on) begin
      obs = {hsync, vsync, red, green, blue};
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("pix h%0d v%0d", e.h, e.v), 32'(obs & e.mask), 32'(e.val));
      end
      chk("vblank_start", 32'(vblank_start), 32'(mhc == 0 && mvc == VA));
      chk("clear_busy", 32'(clear_busy), 32'(m_mode == 2));
      chk("painting", 32'(dut.state == PAINT), 32'(m_mode == 1));
      if (clear_busy) busy_run++;
      else if (busy_run != 0) begin
        chk("clear_len", 32'(busy_run), 32'(NPIX));
        busy_run = 0;
      end

      act = (mhc < HA) && (mvc < VA);
      cx = mhc - CX0;
      cy = mvc - CY0;
      hit = act && cx >= 0 && cx < CW && cy >= 0 && cy < CH;
      e.h = 16'(mhc);
      e.v = 16'(mvc);
      e.val[13] = !(mhc >= HA + HFP && mhc < HA + HFP + HS);
      e.val[12] = !(mvc >= VA + VFP && mvc < VA + VFP + VS);
      e.val[11:0] = 12'h000;
      e.mask = 14'h3FFF;
      if (hit) begin
        if (canvas_ok) e.val[11:0] = PAL[canvas[cy * CW + cx]];
        else           e.mask = 14'h3000;
      end
      sb_q.push_back(e);

      case (m_mode)
        0: begin
          if (clear_req) begin
            m_mode = 2; m_left = NPIX;
          end else if (paint_en && mhc == 0 && mvc == VA) begin
            r = int'(brush_r);
            m_mode = 1; m_left = (2 * r + 1) * (2 * r + 1);
            stamp(int'(x_pos), int'(y_pos), r, int'(color_sel));
          end
        end
        1: begin
          if (clear_req) begin
            m_mode = 2; m_left = NPIX;
          end else begin
            m_left--;
            if (m_left == 0) m_mode = 0;
          end
        end
        default: begin
          m_left--;
          if (m_left == 0) begin
            m_mode = 0;
            foreach (canvas[i]) canvas[i] = 3'd0;
            canvas_ok = 1'b1;
          end
        end
      endcase

      if (mhc == HT - 1) begin
        mhc = 0;
        mvc = (mvc == VT - 1) ? 0 : mvc + 1;
      end else begin
        mhc++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge dclk);
      #1;
    end
  endtask

  task automatic wait_pos(input int h, input int v);
    int guard;
    guard = 0;
    do begin
      step(1);
      guard++;
    end while (!(mhc == h && mvc == v) && guard < 2 * HT * VT);
    chk($sformatf("wait_pos h%0d v%0d", h, v), 32'(mhc == h && mvc == v), 32'd1);
  endtask

  task automatic paint_at_vblank(input int x, input int y, input int c, input int r);
    wait_pos(0, VA);
    x_pos = 10'(x);
    y_pos = 10'(y);
    color_sel = 3'(c);
    brush_r = 4'(r);
    paint_en = 1'b1;
    step(1);
    paint_en = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_req = 1'b1;
    step(1);
    clear_req = 1'b0;
  endtask

  initial begin
    // Outputs while held in reset
    repeat (3) @(posedge dclk);
    @(negedge dclk);
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_rgb", 32'({red, green, blue}), 32'd0);
    chk("rst_clear_busy", 32'(clear_busy), 32'd0);
    chk("rst_vblank_start", 32'(vblank_start), 32'd0);

    // Release and start the scoreboard; first two outputs are reset values
    @(posedge dclk);
    #1;
    clr_n = 1'b1;
    mhc = 0;
    mvc = 0;
    sb_q.push_back('{h: 16'hFFFF, v: 16'hFFFF, val: 14'h3000, mask: 14'h3FFF});
    sb_q.push_back('{h: 16'hFFFF, v: 16'hFFFF, val: 14'h3000, mask: 14'h3FFF});
    sb_on = 1'b1;
    pulse_clear();

    // One all-white frame, then a series of paints each checked on the next frame
    wait_pos(0, VA);
    paint_at_vblank(5, 6, 2, 2);
    paint_at_vblank(0, 0, 5, 3);
    paint_at_vblank(15, 15, 4, 1);
    paint_at_vblank(9, 2, 6, 0);

    // Clear on the 5th paint cycle aborts the paint
    paint_at_vblank(7, 7, 1, 3);
    step(4);
    pulse_clear();

    // Clear running across vblank: the paint request and a second clear are ignored
    wait_pos(0, VA - 2);
    pulse_clear();
    wait_pos(0, VA);
    x_pos = 10'd3;
    y_pos = 10'd3;
    color_sel = 3'd3;
    brush_r = 4'd2;
    paint_en = 1'b1;
    step(1);
    paint_en = 1'b0;
    step(9);
    pulse_clear();
    wait_pos(0, VA);
    paint_at_vblank(12, 1, 4, 1);
    wait_pos(0, VA);

    // Asynchronous reset in the middle of a clear
    sb_on = 1'b0;
    pulse_clear();
    step(10);
    chk("busy_mid_clear", 32'(clear_busy), 32'd1);
    #2;
    clr_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(clear_busy), 32'd0);
    chk("async_rst_state", 32'(dut.state == IDLE), 32'd1);
    chk("async_rst_hsync", 32'(hsync), 32'd1);
    chk("async_rst_rgb", 32'({red, green, blue}), 32'd0);
    step(3);
    clr_n = 1'b1;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_paint_canvas.md
# vga_paint_canvas

Parametrised VGA timing generator with an indexed-colour paint canvas. It scans a configurable active raster and displays a CANVAS_W×CANVAS_H framebuffer at a fixed screen offset, with every other active pixel black. A painter state machine stamps square brushes at a caller-supplied canvas position once per frame and can clear the whole canvas. It sits between the pixel-clock domain (25 MHz for 640×480) and the board VGA pins. It replaces the fixed 640×480 generator with its combinational framebuffer writes.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and pulse lengths (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 29, vertical porch and pulse lengths (lines)
- CANVAS_W / CANVAS_H, 480 / 480, canvas size (pixels)
- CANVAS_X0 / CANVAS_Y0, 80 / 0, canvas top-left in active-screen coordinates
- IDX_W, 3, colour index width (palette of 2^IDX_W entries)
- dclk  in  1  pixel clock; single clock domain
- clr_n  in  1  asynchronous, active-low reset
- paint_en  in  1  request a brush stamp at the next vblank
- x_pos, y_pos  in  10 each  brush centre in canvas coordinates
- color_sel  in  IDX_W  palette index to paint
- brush_r  in  4  brush radius r; square side is 2r+1
- clear_req  in  1  single-cycle pulse: fill canvas with index 0
- clear_busy  out  1  high while a clear is in progress
- vblank_start  out  1  one-cycle pulse at the first vertical-blanking pixel
- hsync, vsync  out  1 each  active-low sync
- red, green, blue  out  4 each  pixel colour

## Operation
- Counters: hc runs 0..H_TOTAL-1 (H_TOTAL = sum of the four H parameters); vc increments on the hc wrap and runs 0..V_TOTAL-1. Order within a line or frame: active, front porch, sync, back porch.
- hsync is low for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync uses the same rule with the V parameters.
- Canvas hit: hc−CANVAS_X0 in [0,CANVAS_W) and vc−CANVAS_Y0 in [0,CANVAS_H). Read address = (vc−CANVAS_Y0)·CANVAS_W + (hc−CANVAS_X0), ADDR_W = clog2(CANVAS_W·CANVAS_H).
- Pixel colour:
  - blanking: 0
  - active, off-canvas: black
  - canvas hit: palette[index]
- Palette, fixed, in the package:
  - 0 white FFF, 1 red F00, 2 orange F80, 3 yellow FF0
  - 4 green 0F0, 5 blue 00F, 6 purple C0C, 7 black 000
- Painter FSM states IDLE, PAINT, CLEAR.
  - IDLE→CLEAR on clear_req. The FSM writes index 0 to addresses 0..CANVAS_W·CANVAS_H−1, one per cycle, then returns to IDLE.
  - IDLE→PAINT on vblank_start with paint_en=1. It latches x_pos, y_pos, color_sel and brush_r at that cycle, then raster-walks rows y−r..y+r and columns x−r..x+r, one pixel per cycle.
  - Points outside the canvas (negative or ≥ size) are skipped but still consume their cycle. There is no wrap to adjacent rows.
  - PAINT→IDLE after the last point.
- Precedence and boundary rules:
  - clear_req in PAINT aborts the paint and enters CLEAR.
  - clear_req in CLEAR is ignored.
  - vblank_start with paint_en during CLEAR is ignored; there is no queueing.
- Framebuffer contents are not reset; software issues clear_req after reset.

## Timing
- Reset values: hc=vc=0, hsync=vsync=1, rgb=0, clear_busy=0, vblank_start=0, FSM=IDLE.
- Reset mid-clear or mid-paint returns to IDLE immediately. Partial writes remain in the RAM.
- Scan pipeline is 2 cycles:
  - stage 0: counters
  - stage 1: address registered into RAM, RAM read
  - stage 2: palette lookup, registered RGB
- hsync, vsync and the blank/hit flags are delayed 2 cycles so they align with RGB.
- vblank_start is asserted at stage 0 for hc=0, vc=V_ACTIVE and is not delayed.
- A write at cycle t is visible to a scan read at cycle t+1. A same-address read in cycle t returns the old data.
- clear_busy rises the cycle after clear_req and lasts exactly CANVAS_W·CANVAS_H cycles.
- A paint takes (2r+1)² cycles, starting the cycle after vblank_start.

## Structure
- Package vga_pkg holds the palette constants, the timing-parameter defaults, and the painter state enum.
- Sub-module canvas_ram: simple dual-port RAM with a write port (painter) and a registered read port (scan), inferred as block RAM.
- Painter FSM, counters and pipeline live in the top level.

## Test plan
- Reset then free-run:
  - hsync period 800 cycles, low for 96, falling at hc=656 (+2 pipeline)
  - vsync period 521 lines, low for 2
  - outputs at reset as listed above
- clear_req: clear_busy high for 230400 cycles. The next frame shows FFF for screen x 80..559 on all active lines, 000 for x 0..79 and 560..639, and 0 in blanking.
- paint_en, x=100, y=200, color 2, r=2: after vblank_start, 25 cycles of painting. The next frame shows F80 at screen x 178..182 on lines 198..202, with RGB appearing 2 cycles after stage-0 hc=178.
- Clipping, x=0, y=0, r=3, color 5: exactly a 4×4 block of 00F at canvas (0..3, 0..3). Canvas row ends at x=479 and the last line are unchanged. Paint lasts 49 cycles.
- clear_req on the 5th cycle of a paint: paint aborts, a full clear runs, and the canvas ends all white.
- paint_en asserted during clear_busy at vblank_start: no paint occurs. Reset asserted mid-clear: clear_busy drops to 0 asynchronously.
